// File: rtl/fir_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_coef_loader
// Brief    : Paces host coefficient words into the FIR bank coefficient port,
//            spacing write strobes for the bank's write-address pipeline.
//            Build option: FIR_LOADER_AUTO_MUTE_EN mutes audio_en during loads.
// Revision : 1.0
// ============================================================================
module fir_coef_loader #(
  parameter int NUM_FILTERS = 4,
  parameter int WR_SPACING  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic        load_abort,
  input  logic [5:0]  load_filter,
  input  logic [8:0]  load_count,
  input  logic        audio_en_req,
  input  logic        coef_valid,
  input  logic [15:0] coef_data,
  output logic        coef_ready,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic        audio_en,
  output logic        coef_addr_rst,
  output logic        coefficient_wr_en,
  output logic [5:0]  coef_select,
  output logic [7:0]  coef_wr_msb_data,
  output logic [7:0]  coef_wr_lsb_data,
  output logic [7:0]  coefs_per_tap_lsb,
  output logic        coefs_per_tap_msb
);

  localparam int               GAP_W    = $clog2(WR_SPACING + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(WR_SPACING);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR_RST  = 3'd1,
    S_WAIT_WORD = 3'd2,
    S_GAP       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       remaining_q, remaining_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [5:0]       select_q, select_d;
  logic [8:0]       per_tap_q, per_tap_d;
  logic [7:0]       msb_q, msb_d;
  logic [7:0]       lsb_q, lsb_d;
  logic             wr_en_q, wr_en_d;
  logic             addr_rst_q, addr_rst_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             audio_q, audio_d;

  logic             w_cmd_bad;

  assign w_cmd_bad = ({26'd0, load_filter} >= 32'(NUM_FILTERS)) || (load_count == 9'd0);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    select_d    = select_q;
    per_tap_d   = per_tap_q;
    msb_d       = msb_q;
    lsb_d       = lsb_q;
    wr_en_d     = 1'b0;
    addr_rst_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (w_cmd_bad) begin
            err_d = 1'b1;
          end else begin
            select_d    = load_filter;
            per_tap_d   = load_count;
            remaining_d = load_count;
            addr_rst_d  = 1'b1;
            state_d     = S_ADDR_RST;
          end
        end
      end
      S_ADDR_RST: begin
        state_d = S_WAIT_WORD;
      end
      S_WAIT_WORD: begin
        if (coef_valid) begin
          msb_d       = coef_data[15:8];
          lsb_d       = coef_data[7:0];
          wr_en_d     = 1'b1;
          remaining_d = remaining_q - 9'd1;
          gap_d       = GAP_LOAD;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q - GAP_LAST;
        if (gap_q <= GAP_LAST) begin
          state_d = (remaining_q != 9'd0) ? S_WAIT_WORD : S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort outranks any handshake or completion decided above.
    if (state_q != S_IDLE) begin
      if (load_start) begin
        err_d = 1'b1;
      end
      if (load_abort) begin
        state_d     = S_IDLE;
        remaining_d = remaining_q;
        msb_d       = msb_q;
        lsb_d       = lsb_q;
        wr_en_d     = 1'b0;
        addr_rst_d  = 1'b0;
        done_d      = 1'b0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
`ifdef FIR_LOADER_AUTO_MUTE_EN
    // Mute also covers the load_done cycle so audio restarts one cycle after it.
    audio_d = audio_en_req && !busy_d && !done_d;
`else
    audio_d = audio_en_req;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= 9'd0;
      gap_q       <= '0;
      select_q    <= 6'd0;
      per_tap_q   <= 9'd0;
      msb_q       <= 8'd0;
      lsb_q       <= 8'd0;
      wr_en_q     <= 1'b0;
      addr_rst_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      audio_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      select_q    <= select_d;
      per_tap_q   <= per_tap_d;
      msb_q       <= msb_d;
      lsb_q       <= lsb_d;
      wr_en_q     <= wr_en_d;
      addr_rst_q  <= addr_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      audio_q     <= audio_d;
    end
  end

  assign coef_ready        = (state_q == S_WAIT_WORD);
  assign busy              = busy_q;
  assign load_done         = done_q;
  assign load_err          = err_q;
  assign audio_en          = audio_q;
  assign coef_addr_rst     = addr_rst_q;
  assign coefficient_wr_en = wr_en_q;
  assign coef_select       = select_q;
  assign coef_wr_msb_data  = msb_q;
  assign coef_wr_lsb_data  = lsb_q;
  assign coefs_per_tap_lsb = per_tap_q[7:0];
  assign coefs_per_tap_msb = per_tap_q[8];

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coef_loader
// Brief    : Scenario bench for fir_coef_loader against a host-side word model.
// Revision : 1.0
// ============================================================================
module tb_fir_coef_loader;

  localparam int NUM_FILTERS = 4;
  localparam int WR_SPACING  = 4;
  localparam int SPACING     = WR_SPACING + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        load_start = 1'b0;
  logic        load_abort = 1'b0;
  logic [5:0]  load_filter = 6'd0;
  logic [8:0]  load_count = 9'd0;
  logic        audio_en_req = 1'b0;
  logic        coef_valid = 1'b0;
  logic [15:0] coef_data = 16'd0;
  logic        coef_ready, busy, load_done, load_err, audio_en;
  logic        coef_addr_rst, coefficient_wr_en, coefs_per_tap_msb;
  logic [5:0]  coef_select;
  logic [7:0]  coef_wr_msb_data, coef_wr_lsb_data, coefs_per_tap_lsb;

  fir_coef_loader #(.NUM_FILTERS(NUM_FILTERS), .WR_SPACING(WR_SPACING)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_abort(load_abort),
    .load_filter(load_filter), .load_count(load_count), .audio_en_req(audio_en_req),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
    .busy(busy), .load_done(load_done), .load_err(load_err), .audio_en(audio_en),
    .coef_addr_rst(coef_addr_rst), .coefficient_wr_en(coefficient_wr_en),
    .coef_select(coef_select), .coef_wr_msb_data(coef_wr_msb_data),
    .coef_wr_lsb_data(coef_wr_lsb_data), .coefs_per_tap_lsb(coefs_per_tap_lsb),
    .coefs_per_tap_msb(coefs_per_tap_msb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [37:0] all_outs;
  assign all_outs = {busy, load_done, load_err, audio_en, coef_addr_rst, coefficient_wr_en,
                     coef_ready, coef_select, coef_wr_msb_data, coef_wr_lsb_data,
                     coefs_per_tap_lsb, coefs_per_tap_msb};

  // Event log written only by this monitor; tasks read deltas against saved bases.
  int          st_cyc[$];
  logic [15:0] st_data[$];
  int          rst_cyc[$];
  int          done_cyc[$];
  int          err_cnt = 0;
  int          busy_cnt = 0;
  logic        aud_log[int];

  always @(negedge clk) begin
    if (reset_n) begin
      if (coefficient_wr_en) begin
        st_cyc.push_back(cyc);
        st_data.push_back({coef_wr_msb_data, coef_wr_lsb_data});
      end
      if (coef_addr_rst) rst_cyc.push_back(cyc);
      if (load_done) done_cyc.push_back(cyc);
      if (load_err) err_cnt = err_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      aud_log[cyc] = audio_en;
    end
  end

  int          tests = 0;
  int          fails = 0;
  logic [15:0] host_words[$];
  logic [5:0]  exp_sel = 6'd0;
  logic [8:0]  exp_cpt = 9'd0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue_start(input logic [5:0] f, input logic [8:0] c, output int acc);
    tick();
    load_start  = 1'b1;
    load_filter = f;
    load_count  = c;
    acc         = cyc + 1;
    tick();
    load_start  = 1'b0;
  endtask

  task automatic fill_words(input int n);
    host_words = {};
    for (int i = 0; i < n; i++) host_words.push_back(16'($urandom));
  endtask

  task automatic feed(input int n, input int gap_pct, output int first_rdy, output logic timeout);
    int   idx;
    int   budget;
    logic hs;
    idx = 0; budget = 0; hs = 1'b0; first_rdy = -1; timeout = 1'b0;
    while (idx < n && !timeout) begin
      tick();
      budget++;
      if (hs) idx++;
      if (first_rdy < 0 && coef_ready) first_rdy = cyc;
      if (idx < n) begin
        coef_valid = ($urandom_range(99) >= gap_pct);
        coef_data  = host_words[idx];
      end else begin
        coef_valid = 1'b0;
      end
      hs = coef_valid && coef_ready;
      if (budget > 20 * n + 50) timeout = 1'b1;
    end
    coef_valid = 1'b0;
  endtask

  task automatic wait_done(input int base, output logic timeout);
    int b;
    b = 0;
    while (done_cyc.size() <= base && b < 200) begin
      tick();
      b++;
    end
    timeout = (done_cyc.size() <= base);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    audio_en_req = 1'b1;
    repeat (3) tick();
    tests++;
    if (all_outs !== 38'd0) begin
      fails++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    reset_n = 1'b1;
    tick();
    tests++;
    if (audio_en !== 1'b1 || busy !== 1'b0 || coef_ready !== 1'b0) begin
      fails++; $display("FAIL reset_idle: audio_en=%b busy=%b ready=%b expected 1/0/0", audio_en, busy, coef_ready);
    end
    exp_sel = 6'd0; exp_cpt = 9'd0;
  endtask

  task automatic test_basic_load();
    int b_st, b_rst, b_done, acc, first_rdy, n;
    logic to;
    b_st = st_cyc.size(); b_rst = rst_cyc.size(); b_done = done_cyc.size();
    host_words = {16'h1234, 16'hABCD, 16'h8001};
    issue_start(6'd2, 9'd3, acc);
    exp_sel = 6'd2; exp_cpt = 9'd3;
    feed(3, 0, first_rdy, to);
    wait_done(b_done, to);
    tick();
    tests++;
    if (to) begin fails++; $display("FAIL basic_timeout: no load_done seen, required one"); end
    tests++;
    if (rst_cyc.size() - b_rst !== 1 || rst_cyc[b_rst] !== acc) begin
      fails++; $display("FAIL basic_addr_rst: pulses=%0d first_at=%0d expected 1 at %0d",
                        rst_cyc.size() - b_rst, (rst_cyc.size() > b_rst) ? rst_cyc[b_rst] : -1, acc);
    end
    tests++;
    if (first_rdy !== acc + 1) begin
      fails++; $display("FAIL basic_ready: first ready cycle %0d expected %0d", first_rdy, acc + 1);
    end
    n = st_cyc.size() - b_st;
    tests++;
    if (n !== 3) begin fails++; $display("FAIL basic_strobes: got %0d expected 3", n); end
    if (n > 0) begin
      tests++;
      if (st_cyc[b_st] !== acc + 2) begin
        fails++; $display("FAIL basic_first_strobe: at %0d expected %0d", st_cyc[b_st], acc + 2);
      end
    end
    for (int i = 0; i < n && i < 3; i++) begin
      tests++;
      if (st_data[b_st + i] !== host_words[i]) begin
        fails++; $display("FAIL basic_data[%0d]: got %h expected %h", i, st_data[b_st + i], host_words[i]);
      end
      if (i > 0) begin
        tests++;
        if (st_cyc[b_st + i] - st_cyc[b_st + i - 1] !== SPACING) begin
          fails++; $display("FAIL basic_spacing[%0d]: got %0d expected %0d", i,
                            st_cyc[b_st + i] - st_cyc[b_st + i - 1], SPACING);
        end
      end
    end
    tests++;
    if (coef_select !== exp_sel || {coefs_per_tap_msb, coefs_per_tap_lsb} !== exp_cpt) begin
      fails++; $display("FAIL basic_sel_cpt: sel=%0d cpt=%0d expected %0d/%0d", coef_select,
                        {coefs_per_tap_msb, coefs_per_tap_lsb}, exp_sel, exp_cpt);
    end
    tests++;
    if (done_cyc.size() - b_done !== 1 || n == 0 || done_cyc[b_done] - st_cyc[st_cyc.size() - 1] !== SPACING) begin
      fails++; $display("FAIL basic_done: pulses=%0d expected 1 at %0d cycles after last strobe",
                        done_cyc.size() - b_done, SPACING);
    end
    tests++;
    if ({coef_wr_msb_data, coef_wr_lsb_data} !== 16'h8001 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_hold: data=%h busy=%b expected 8001/0", {coef_wr_msb_data, coef_wr_lsb_data}, busy);
    end
  endtask

  task automatic test_reject();
    logic [5:0] f[4];
    logic [8:0] c[4];
    int b_err, b_busy, b_st, acc;
    f[0] = 6'd4; c[0] = 9'd5;
    f[1] = 6'd0; c[1] = 9'd0;
    f[2] = 6'($urandom_range(63, NUM_FILTERS)); c[2] = 9'($urandom_range(511, 1));
    f[3] = 6'($urandom_range(NUM_FILTERS - 1, 0)); c[3] = 9'd0;
    for (int k = 0; k < 4; k++) begin
      b_err = err_cnt; b_busy = busy_cnt; b_st = st_cyc.size();
      issue_start(f[k], c[k], acc);
      repeat (3) tick();
      tests++;
      if (err_cnt - b_err !== 1 || busy_cnt !== b_busy || st_cyc.size() !== b_st) begin
        fails++; $display("FAIL reject[%0d]: err=%0d busy_cycles=%0d strobes=%0d expected 1/0/0", k,
                          err_cnt - b_err, busy_cnt - b_busy, st_cyc.size() - b_st);
      end
      tests++;
      if (coef_select !== exp_sel || {coefs_per_tap_msb, coefs_per_tap_lsb} !== exp_cpt) begin
        fails++; $display("FAIL reject_hold[%0d]: sel=%0d cpt=%0d expected %0d/%0d", k, coef_select,
                          {coefs_per_tap_msb, coefs_per_tap_lsb}, exp_sel, exp_cpt);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int b_err, b_st, b_done, acc, fr;
    logic to;
    b_err = err_cnt; b_st = st_cyc.size(); b_done = done_cyc.size();
    fill_words(2);
    issue_start(6'd1, 9'd2, acc);
    exp_sel = 6'd1; exp_cpt = 9'd2;
    load_start = 1'b1; load_filter = 6'd3; load_count = 9'd7;
    tick();
    load_start = 1'b0;
    feed(2, 0, fr, to);
    wait_done(b_done, to);
    tick();
    tests++;
    if (err_cnt - b_err !== 1 || to) begin
      fails++; $display("FAIL busy_start_err: err=%0d timeout=%b expected 1/0", err_cnt - b_err, to);
    end
    tests++;
    if (st_cyc.size() - b_st !== 2 || coef_select !== exp_sel || {coefs_per_tap_msb, coefs_per_tap_lsb} !== exp_cpt) begin
      fails++; $display("FAIL busy_start_load: strobes=%0d sel=%0d cpt=%0d expected 2/%0d/%0d", st_cyc.size() - b_st,
                        coef_select, {coefs_per_tap_msb, coefs_per_tap_lsb}, exp_sel, exp_cpt);
    end
  endtask

  task automatic test_long_load();
    int b_st, b_done, acc, fr, n, viol, bad;
    logic to;
    b_st = st_cyc.size(); b_done = done_cyc.size();
    fill_words(300);
    exp_sel = 6'($urandom_range(NUM_FILTERS - 1, 0)); exp_cpt = 9'd300;
    issue_start(exp_sel, exp_cpt, acc);
    tests++;
    if (coefs_per_tap_msb !== 1'b1 || coefs_per_tap_lsb !== 8'h2C || coef_select !== exp_sel) begin
      fails++; $display("FAIL long_cpt: msb=%b lsb=%h sel=%0d expected 1/2c/%0d", coefs_per_tap_msb,
                        coefs_per_tap_lsb, coef_select, exp_sel);
    end
    feed(300, 30, fr, to);
    wait_done(b_done, to);
    tick();
    n = st_cyc.size() - b_st;
    tests++;
    if (n !== 300 || to) begin fails++; $display("FAIL long_strobes: got %0d timeout=%b expected 300/0", n, to); end
    viol = 0; bad = 0;
    for (int i = 0; i < n && i < 300; i++) begin
      if (st_data[b_st + i] !== host_words[i]) bad++;
      if (i > 0 && st_cyc[b_st + i] - st_cyc[b_st + i - 1] < SPACING) viol++;
    end
    tests++;
    if (viol !== 0) begin fails++; $display("FAIL long_spacing: %0d close strobes expected 0", viol); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL long_data: %0d wrong words expected 0", bad); end
    tests++;
    if (done_cyc.size() - b_done !== 1 || n == 0 || done_cyc[b_done] - st_cyc[st_cyc.size() - 1] !== SPACING) begin
      fails++; $display("FAIL long_done: pulses=%0d expected 1 at spacing %0d", done_cyc.size() - b_done, SPACING);
    end
  endtask

  task automatic test_abort();
    int b_st, b_done, acc, n, b;
    audio_en_req = 1'b1;
    b_st = st_cyc.size(); b_done = done_cyc.size();
    fill_words(5);
    exp_sel = 6'($urandom_range(NUM_FILTERS - 1, 0)); exp_cpt = 9'd5;
    issue_start(exp_sel, exp_cpt, acc);
    coef_data = host_words[0]; coef_valid = 1'b1;
    n = 0; b = 0;
    while (b < 100) begin
      tick(); b++;
      n = st_cyc.size() - b_st;
      if (n >= 2) break;
      coef_data = host_words[n];
    end
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0; coef_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || coef_ready !== 1'b0 || audio_en !== 1'b1) begin
      fails++; $display("FAIL abort_idle: busy=%b ready=%b audio_en=%b expected 0/0/1", busy, coef_ready, audio_en);
    end
    repeat (20) tick();
    tests++;
    if (st_cyc.size() - b_st !== 2 || done_cyc.size() !== b_done) begin
      fails++; $display("FAIL abort_after: strobes=%0d done=%0d expected 2/0", st_cyc.size() - b_st, done_cyc.size() - b_done);
    end
    for (int i = 0; i < 2 && i < st_cyc.size() - b_st; i++) begin
      tests++;
      if (st_data[b_st + i] !== host_words[i]) begin
        fails++; $display("FAIL abort_data[%0d]: got %h expected %h", i, st_data[b_st + i], host_words[i]);
      end
    end
    b_st = st_cyc.size();
    issue_start(exp_sel, 9'd3, acc);
    exp_cpt = 9'd3;
    b = 0;
    while (!coef_ready && b < 10) begin tick(); b++; end
    coef_valid = 1'b1; load_abort = 1'b1;
    tick();
    coef_valid = 1'b0; load_abort = 1'b0;
    repeat (8) tick();
    tests++;
    if (st_cyc.size() !== b_st || busy !== 1'b0 || done_cyc.size() !== b_done) begin
      fails++; $display("FAIL abort_priority: strobes=%0d busy=%b done=%0d expected 0/0/0",
                        st_cyc.size() - b_st, busy, done_cyc.size() - b_done);
    end
  endtask

  task automatic test_reset_midload();
    int b_st, b_done, acc, fr, b;
    logic to;
    b_st = st_cyc.size();
    fill_words(4);
    issue_start(6'd1, 9'd4, acc);
    coef_data = host_words[0]; coef_valid = 1'b1;
    b = 0;
    while (st_cyc.size() == b_st && b < 20) begin tick(); b++; end
    tick();
    reset_n = 1'b0;
    #1;
    tests++;
    if (all_outs !== 38'd0) begin fails++; $display("FAIL midreset_outs: got %h expected 0", all_outs); end
    b_st = st_cyc.size();
    repeat (3) tick();
    reset_n = 1'b1; coef_valid = 1'b0;
    exp_sel = 6'd0; exp_cpt = 9'd0;
    repeat (2) tick();
    tests++;
    if (st_cyc.size() !== b_st || busy !== 1'b0) begin
      fails++; $display("FAIL midreset_quiet: strobes=%0d busy=%b expected 0/0", st_cyc.size() - b_st, busy);
    end
    b_done = done_cyc.size();
    fill_words(1);
    issue_start(6'd3, 9'd1, acc);
    exp_sel = 6'd3; exp_cpt = 9'd1;
    feed(1, 0, fr, to);
    wait_done(b_done, to);
    tick();
    tests++;
    if (to || st_cyc.size() - b_st !== 1 || done_cyc.size() - b_done !== 1) begin
      fails++; $display("FAIL midreset_reload: strobes=%0d done=%0d timeout=%b expected 1/1/0",
                        st_cyc.size() - b_st, done_cyc.size() - b_done, to);
    end
    tests++;
    if (st_data.size() == 0 || st_data[st_data.size() - 1] !== host_words[0] ||
        coef_select !== exp_sel || {coefs_per_tap_msb, coefs_per_tap_lsb} !== exp_cpt) begin
      fails++; $display("FAIL midreset_values: data=%h sel=%0d cpt=%0d expected %h/%0d/%0d",
                        {coef_wr_msb_data, coef_wr_lsb_data}, coef_select,
                        {coefs_per_tap_msb, coefs_per_tap_lsb}, host_words[0], exp_sel, exp_cpt);
    end
  endtask

  task automatic test_audio();
    int b_done, acc, fr, d, mism;
    logic to, exp_a;
    audio_en_req = 1'b1;
    repeat (3) tick();
    b_done = done_cyc.size();
    fill_words(2);
    exp_sel = 6'($urandom_range(NUM_FILTERS - 1, 0)); exp_cpt = 9'd2;
    issue_start(exp_sel, exp_cpt, acc);
    feed(2, 0, fr, to);
    wait_done(b_done, to);
    repeat (3) tick();
    d = to ? acc + 100 : done_cyc[b_done];
    mism = 0;
    for (int c = acc - 2; c <= d + 2; c++) begin
`ifdef FIR_LOADER_AUTO_MUTE_EN
      exp_a = !(c >= acc && c <= d);
`else
      exp_a = 1'b1;
`endif
      if (!aud_log.exists(c)) mism++;
      else if (aud_log[c] !== exp_a) mism++;
    end
    tests++;
    if (mism !== 0 || to) begin
      fails++; $display("FAIL audio_window: %0d wrong cycles timeout=%b expected 0/0", mism, to);
    end
    audio_en_req = 1'b0;
    tick();
    tests++;
    if (audio_en !== 1'b0) begin fails++; $display("FAIL audio_follow_low: got %b expected 0", audio_en); end
    audio_en_req = 1'b1;
    tick();
    tests++;
    if (audio_en !== 1'b1) begin fails++; $display("FAIL audio_follow_high: got %b expected 1", audio_en); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_reject();
    test_start_while_busy();
    test_long_load();
    test_abort();
    test_reset_midload();
    test_audio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
